// File: rtl/ir_evt_pkg.sv
// Shared event-type codes and FSM state encoding for the IR command event block.
package ir_evt_pkg;
   localparam int unsigned EVT_W = 2;

   typedef logic [EVT_W-1:0] evt_t;

   localparam evt_t EVT_NONE    = 2'b00;
   localparam evt_t EVT_NEW     = 2'b01;
   localparam evt_t EVT_REPEAT  = 2'b10;
   localparam evt_t EVT_RELEASE = 2'b11;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StHeld = 1'b1
   } state_t;
endpackage

// File: rtl/ir_evt_fifo.sv
// Event FIFO: power-of-two depth, drops writes when full unless a pop frees a slot on the same edge.
module ir_evt_fifo #(
   parameter int unsigned WIDTH = 22,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             ovf
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             ovf_q;
   logic             do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_rd   = rd && !empty;
   assign do_wr   = wr && (!full || do_rd);
   assign rd_data = mem[rd_ptr_q];
   assign ovf     = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
         ovf_q   <= wr && !do_wr;
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/ir_cmd_event.sv
// Turns decoded IR frames and repeat strobes into NEW/REPEAT/RELEASE events queued in a FIFO.
// Optional macro IR_EVT_RELEASE_EN enables RELEASE events on hold timeout.
module ir_cmd_event
   import ir_evt_pkg::*;
#(
   parameter int unsigned DATA_W     = 20,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned REPEAT_DIV = 1,
   parameter int unsigned HOLD_TMO   = 12000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_repeat,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [EVT_W-1:0]  evt_type,
   output logic [DATA_W-1:0] evt_data,
   output logic              held,
   output logic              ovf
);
   localparam int unsigned TW = $clog2(HOLD_TMO + 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic [7:0]        rpt_q, rpt_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              pend_q, pend_d;
   evt_t              pend_type_q, pend_type_d;
   logic [DATA_W-1:0] pend_data_q, pend_data_d;

   logic                    fifo_empty, fifo_full;
   logic [EVT_W+DATA_W-1:0] fifo_head;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      rpt_d       = rpt_q;
      tmr_d       = tmr_q;
      pend_d      = 1'b0;
      pend_type_d = EVT_NONE;
      pend_data_d = '0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               pend_d      = 1'b1;
               pend_type_d = EVT_NEW;
               pend_data_d = in_data;
               last_d      = in_data;
               state_d     = StHeld;
               tmr_d       = '0;
               rpt_d       = '0;
            end
         end
         StHeld: begin
            if (in_valid && (in_data != last_q)) begin
               pend_d      = 1'b1;
               pend_type_d = EVT_NEW;
               pend_data_d = in_data;
               last_d      = in_data;
               tmr_d       = '0;
               rpt_d       = '0;
            end else if (in_valid || in_repeat) begin
               // A re-sent identical frame counts as a repeat code.
               tmr_d = '0;
               if (rpt_q == 8'(REPEAT_DIV - 1)) begin
                  pend_d      = 1'b1;
                  pend_type_d = EVT_REPEAT;
                  pend_data_d = last_q;
                  rpt_d       = '0;
               end else begin
                  rpt_d = rpt_q + 8'd1;
               end
            end else if (tmr_q == TW'(HOLD_TMO - 1)) begin
               state_d = StIdle;
               rpt_d   = '0;
               tmr_d   = '0;
`ifdef IR_EVT_RELEASE_EN
               pend_d      = 1'b1;
               pend_type_d = EVT_RELEASE;
               pend_data_d = last_q;
`else
               pend_d      = 1'b0;
`endif
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= '0;
         rpt_q       <= '0;
         tmr_q       <= '0;
         pend_q      <= 1'b0;
         pend_type_q <= EVT_NONE;
         pend_data_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         rpt_q       <= rpt_d;
         tmr_q       <= tmr_d;
         pend_q      <= pend_d;
         pend_type_q <= pend_type_d;
         pend_data_q <= pend_data_d;
      end
   end

   ir_evt_fifo #(
      .WIDTH (EVT_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (pend_q),
      .wr_data ({pend_type_q, pend_data_q}),
      .full    (fifo_full),
      .rd      (evt_ready),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .ovf     (ovf)
   );

   assign evt_valid = !fifo_empty;
   assign evt_type  = fifo_empty ? EVT_NONE : fifo_head[DATA_W +: EVT_W];
   assign evt_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
   assign held      = (state_q == StHeld);
endmodule

// File: tb/tb_ir_cmd_event.sv
// Directed bench for ir_cmd_event with an event scoreboard; honours IR_EVT_RELEASE_EN.
module tb_ir_cmd_event;
   localparam int unsigned DATA_W = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_repeat = 1'b0;
   logic              evt_valid;
   logic              evt_ready = 1'b1;
   logic [1:0]        evt_type;
   logic [DATA_W-1:0] evt_data;
   logic              held;
   logic              ovf;

   typedef struct packed {
      logic [1:0]        t;
      logic [DATA_W-1:0] d;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   ovf_cnt = 0;
   int   cyc;

   ir_cmd_event #(
      .DATA_W     (DATA_W),
      .DEPTH      (4),
      .REPEAT_DIV (3),
      .HOLD_TMO   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_repeat (in_repeat),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_type  (evt_type),
      .evt_data  (evt_data),
      .held      (held),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic v, input logic r, input logic [DATA_W-1:0] d);
      in_valid  = v;
      in_repeat = r;
      in_data   = d;
      tick(1);
      in_valid  = 1'b0;
      in_repeat = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      sb.delete();
   endtask

   // Scoreboard: each accepted head must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && ovf) ovf_cnt++;
      if (!rst && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_evt", {10'd0, evt_type, evt_data}, 32'hffff_ffff);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("evt_type", {30'd0, evt_type}, {30'd0, e.t});
            check("evt_data", {12'd0, evt_data}, {12'd0, e.d});
         end
      end
   end

   initial begin
      // Reset state
      tick(2);
      rst = 1'b0;
      check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
      check("rst_evt_type", {30'd0, evt_type}, 32'd0);
      check("rst_evt_data", {12'd0, evt_data}, 32'd0);
      check("rst_held", {31'd0, held}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);

      // First frame: two-cycle latency to evt_valid
      sb.push_back('{t: 2'b01, d: 20'hABCDE});
      strobe(1'b1, 1'b0, 20'hABCDE);
      check("lat_k_valid", {31'd0, evt_valid}, 32'd0);
      check("lat_held", {31'd0, held}, 32'd1);
      tick(1);
      check("lat_k1_valid", {31'd0, evt_valid}, 32'd1);
      check("lat_k1_type", {30'd0, evt_type}, 32'd1);
      check("lat_k1_data", {12'd0, evt_data}, 32'hABCDE);

      // Six repeats with divider 3 give two REPEAT events
      sb.push_back('{t: 2'b10, d: 20'hABCDE});
      sb.push_back('{t: 2'b10, d: 20'hABCDE});
      repeat (6) strobe(1'b0, 1'b1, 20'h0);
      tick(4);
      check("rpt_sb_empty", sb.size(), 32'd0);

      // Hold timeout
      do_reset();
      sb.push_back('{t: 2'b01, d: 20'h12345});
      strobe(1'b1, 1'b0, 20'h12345);
      cyc = 0;
      for (int i = 1; i <= 24; i++) begin
         tick(1);
         cyc = i;
         if (!held) break;
      end
      check("tmo_cycles", cyc, 32'd16);
`ifdef IR_EVT_RELEASE_EN
      sb.push_back('{t: 2'b11, d: 20'h12345});
`endif
      tick(4);
      check("tmo_sb_empty", sb.size(), 32'd0);

      // Overflow: four queued, fifth dropped
      do_reset();
      ovf_cnt   = 0;
      evt_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) sb.push_back('{t: 2'b01, d: DATA_W'(i * 32'h11111)});
         strobe(1'b1, 1'b0, DATA_W'(i * 32'h11111));
      end
      tick(2);
      check("ovf_count", ovf_cnt, 32'd1);
      check("ovf_head_valid", {31'd0, evt_valid}, 32'd1);
      check("ovf_head_data", {12'd0, evt_data}, 32'h11111);
      tick(3);
      check("ovf_head_stable", {10'd0, evt_type, evt_data}, {10'd0, 2'b01, 20'h11111});
      evt_ready = 1'b1;
      tick(6);
      check("ovf_drained", sb.size(), 32'd0);
      check("ovf_count_final", ovf_cnt, 32'd1);

      // in_valid beats in_repeat; in_valid beats timeout
      do_reset();
      sb.push_back('{t: 2'b01, d: 20'h00001});
      strobe(1'b1, 1'b1, 20'h00001);
      tick(15);
      strobe(1'b1, 1'b0, 20'h00001);
      check("prio_held", {31'd0, held}, 32'd1);
      tick(4);
      check("prio_held_later", {31'd0, held}, 32'd1);
      check("prio_sb_empty", sb.size(), 32'd0);

      // Reset discards queued events
      do_reset();
      evt_ready = 1'b0;
      strobe(1'b1, 1'b0, 20'h0AAAA);
      strobe(1'b1, 1'b0, 20'h0BBBB);
      strobe(1'b1, 1'b0, 20'h0CCCC);
      tick(2);
      check("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
      check("pre_rst_held", {31'd0, held}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      sb.delete();
      check("post_rst_valid", {31'd0, evt_valid}, 32'd0);
      check("post_rst_held", {31'd0, held}, 32'd0);
      check("post_rst_data", {10'd0, evt_type, evt_data}, 32'd0);
      evt_ready = 1'b1;
      strobe(1'b0, 1'b1, 20'h0);
      tick(4);
      check("idle_rpt_valid", {31'd0, evt_valid}, 32'd0);
      check("idle_rpt_held", {31'd0, held}, 32'd0);
      check("idle_rpt_sb", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ir_cmd_event.md
IR_CMD_EVENT -- requirements
Module: ir_cmd_event

Interface
REQ-001 Parameter DATA_W, default 20, width of decoded IR command word.
REQ-002 Parameter DEPTH, default 4, event FIFO entries; power of two, >= 2.
REQ-003 Parameter REPEAT_DIV, default 1, repeat frames per emitted REPEAT event; range 1..255.
REQ-004 Parameter HOLD_TMO, default 12000000, idle clock cycles in HELD before key release (120 ms at 100 MHz); >= 2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  one-cycle strobe: full frame decoded, in_data valid.
REQ-008 in_data  input  DATA_W  decoded command, sampled only when in_valid=1.
REQ-009 in_repeat  input  1  one-cycle strobe: repeat code received.
REQ-010 evt_valid  output  1  FIFO head event valid.
REQ-011 evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-012 evt_type  output  2  head event type: NEW=01, REPEAT=10, RELEASE=11.
REQ-013 evt_data  output  DATA_W  command associated with head event.
REQ-014 held  output  1  high while FSM is in HELD.
REQ-015 ovf  output  1  one-cycle pulse: event dropped, FIFO full.

Function
REQ-016 FSM states IDLE and HELD; register last_data (DATA_W), repeat counter (8 bit), hold timer (width $clog2(HOLD_TMO+1)).
REQ-017 in_valid in IDLE: emit NEW{in_data}, last_data<=in_data, go HELD, timer and repeat counter cleared.
REQ-018 in_valid in HELD with in_data != last_data: emit NEW{in_data}, update last_data, clear timer and repeat counter, stay HELD.
REQ-019 in_valid in HELD with in_data == last_data: treated exactly as in_repeat (REQ-020).
REQ-020 in_repeat in HELD: clear timer; if counter == REPEAT_DIV-1 emit REPEAT{last_data} and clear counter, else increment counter.
REQ-021 in_repeat in IDLE: ignored, no event, no state change.
REQ-022 in_valid and in_repeat in same cycle: in_valid wins, in_repeat ignored.
REQ-023 In HELD with no strobe, timer increments; on reaching HOLD_TMO-1: go IDLE, clear counter, emit RELEASE{last_data} when REQ-033 applies.
REQ-024 Timeout and in_valid in same cycle: in_valid wins, no RELEASE, timer cleared.
REQ-025 At most one event generated per cycle; generated event registered at edge k (strobe sampled), written to FIFO at edge k+1; with FIFO empty, evt_valid high after edge k+1 (2-cycle latency).
REQ-026 Handshake: head pops on edge where evt_valid & evt_ready; evt_type/evt_data stable while evt_valid=1 and evt_ready=0.
REQ-027 FIFO full and write without pop: event dropped, ovf pulses 1 cycle, FIFO unchanged; FSM state updates regardless.
REQ-028 FIFO full with write and pop same edge: write accepted, no ovf.
REQ-029 Pointers wrap modulo DEPTH; occupancy counter width $clog2(DEPTH)+1 distinguishes full from empty.
REQ-030 held asserted from edge entering HELD to edge leaving it.

Reset
REQ-031 rst=1 at an edge: state IDLE, last_data=0, counter=0, timer=0, FIFO emptied, pending event discarded.
REQ-032 Outputs in reset: evt_valid=0, evt_type=00, evt_data=0, held=0, ovf=0; reset mid-event loses all queued events.

Configuration
REQ-033 Macro IR_EVT_RELEASE_EN defined: timeout emits RELEASE; undefined: timeout returns to IDLE silently, code 11 never produced.

Structure
REQ-034 Package ir_evt_pkg holds event type constants EVT_NEW/EVT_REPEAT/EVT_RELEASE, FSM state encodings, event-type width.
REQ-035 FIFO is sub-module ir_evt_fifo (parameters WIDTH, DEPTH; wr/full, rd/empty, ovf); FSM stays in ir_cmd_event.

Verification
REQ-036 Reset, in_valid with in_data=0xABCDE -> after 2 cycles evt_valid=1, type 01, data 0xABCDE; held=1.
REQ-037 REPEAT_DIV=3, HELD 0xABCDE, 6 in_repeat strobes -> exactly 2 REPEAT events, data 0xABCDE.
REQ-038 HOLD_TMO=16, one frame 0x12345, no strobes -> held drops 16 cycles later; RELEASE 0x12345 with macro, none without.
REQ-039 DEPTH=4, evt_ready=0, 5 distinct frames -> 4 NEW queued in order, ovf pulses once; then evt_ready=1 drains 4 in order.
REQ-040 in_valid 0x00001 and in_repeat same cycle, then timer at HOLD_TMO-1 with in_valid 0x00001 -> one NEW only, no REPEAT, no RELEASE.
REQ-041 rst pulsed with 3 events queued and held=1 -> next cycle evt_valid=0, held=0, following in_repeat yields no event.
